// File: rtl/mcyc_main_ctrl.sv
// rtl/mcyc_main_ctrl.sv - MIPS32 multi-cycle main control FSM (optional ILLEGAL_HALT_EN: illegal op/funct halts)
module mcyc_main_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       rega_write,
  output logic       regb_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
    MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    I_EXEC = 4'd10, I_WB = 4'd11, JR = 4'd12, HALT = 4'd13
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  state_t        dec_state;
  logic          dec_illegal;
  logic          mem_state;
  logic          mem_timeout;

  // Instruction classification from op/funct, used by DECODE
  always_comb begin
    dec_state   = FETCH;
    dec_illegal = 1'b0;
    case (op)
      6'h00: begin
        if (func == 6'h08) begin
          dec_state = JR;
        end else if (func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) begin
          dec_state = R_EXEC;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'h02:                                dec_state = JUMP;
      6'h04, 6'h05:                         dec_state = BRANCH;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E:    dec_state = I_EXEC;
      6'h23, 6'h2B:                         dec_state = MEM_ADDR;
      default:                              dec_illegal = 1'b1;
    endcase
`ifdef ILLEGAL_HALT_EN
    if (dec_illegal) dec_state = HALT;
`else
    if (dec_illegal) dec_state = FETCH;
`endif
  end

  // Wait-limit detection for the three states that talk to memory
  always_comb begin
    mem_state   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    mem_timeout = mem_state && !mem_ready && (cnt_q == CW'(MEM_WAIT_MAX));
  end

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic; the counter restarts at zero whenever a memory state is left
  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
    cnt_d     = (mem_state && !mem_ready && !mem_timeout) ? cnt_q + 1'b1 : '0;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE:   state_d = dec_state;
      MEM_ADDR: state_d = (op == 6'h23) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JR: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
    if (mem_timeout) begin
      state_d   = HALT;
      mem_err_d = 1'b1;
    end
  end

  // Datapath controls; everything is forced to zero while reset is held
  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; mdr_write = 1'b0; rega_write = 1'b0;
    regb_write = 1'b0; aluout_write = 1'b0; reg_write = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; iord = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
    alu_src_a = 1'b0; alu_src_b = 3'd0; pc_src = 2'd0; alu_op = ALU_AND;
    instr_done = 1'b0; halted = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1; alu_src_b = 3'd4; alu_op = ALU_ADD;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_b = 3'd3; alu_op = ALU_ADD;
`ifdef ILLEGAL_HALT_EN
        rega_write = !dec_illegal; regb_write = !dec_illegal; aluout_write = !dec_illegal;
`else
        rega_write = 1'b1; regb_write = 1'b1; aluout_write = 1'b1;
        instr_done = dec_illegal;
`endif
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1; alu_src_b = 3'd2; alu_op = ALU_ADD; aluout_write = 1'b1;
      end
      MEM_RD: begin
        mem_read = 1'b1; iord = 1'b1; mdr_write = mem_ready;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1; iord = 1'b1; instr_done = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1; aluout_write = 1'b1;
        case (func)
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h26:   alu_op = ALU_XOR;
          6'h27:   alu_op = ALU_NOR;
          6'h2A:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      R_WB: begin
        reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1; aluout_write = 1'b1;
        case (op)
          6'h0A:   begin alu_src_b = 3'd2; alu_op = ALU_SLT; end
          6'h0C:   begin alu_src_b = 3'd5; alu_op = ALU_AND; end
          6'h0D:   begin alu_src_b = 3'd5; alu_op = ALU_OR;  end
          6'h0E:   begin alu_src_b = 3'd5; alu_op = ALU_XOR; end
          default: begin alu_src_b = 3'd2; alu_op = ALU_ADD; end
        endcase
      end
      I_WB: begin
        reg_write = 1'b1; instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = 2'd1; instr_done = 1'b1;
        pc_write = (op == 6'h04) ? zero : !zero;
      end
      JUMP: begin
        pc_src = 2'd2; pc_write = 1'b1; instr_done = 1'b1;
      end
      JR: begin
        pc_src = 2'd3; pc_write = 1'b1; instr_done = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    if (!nrst) begin
      pc_write = 1'b0; ir_write = 1'b0; mdr_write = 1'b0; rega_write = 1'b0;
      regb_write = 1'b0; aluout_write = 1'b0; reg_write = 1'b0; mem_read = 1'b0;
      mem_write = 1'b0; iord = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
      alu_src_a = 1'b0; alu_src_b = 3'd0; pc_src = 2'd0; alu_op = ALU_AND;
      instr_done = 1'b0; halted = 1'b0;
    end
  end

  // Status outputs
  always_comb begin
    mem_err   = mem_err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mcyc_main_ctrl.sv
// tb/tb_mcyc_main_ctrl.sv - randomized trace check of mcyc_main_ctrl against an instruction-level model
module tb_mcyc_main_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, mdr_write, rega_write, regb_write, aluout_write;
  logic       reg_write, mem_read, mem_write, iord, mem_to_reg, reg_dst, alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       instr_done, halted, mem_err;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcyc_main_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .nrst(nrst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mdr_write(mdr_write),
    .rega_write(rega_write), .regb_write(regb_write), .aluout_write(aluout_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, mdrw, aw, bw, aow, rw, mr, mw, iord, m2r, rdst, srca;
    logic [2:0] srcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic done, halted, err;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       rdy;
    outs_t      exp;
  } cyc_t;

  cyc_t q[$];

  function automatic outs_t got();
    return {state_dbg, pc_write, ir_write, mdr_write, rega_write, regb_write, aluout_write,
            reg_write, mem_read, mem_write, iord, mem_to_reg, reg_dst, alu_src_a,
            alu_src_b, pc_src, alu_op, instr_done, halted, mem_err};
  endfunction

  task automatic chk(input string tag, input outs_t e);
    outs_t g;
    g = got();
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, g, e);
    end
  endtask

  task automatic push(input outs_t o, input logic [5:0] op_i, input logic [5:0] fn_i,
                      input logic rdy_i, input logic z_i);
    cyc_t c;
    c.op = op_i; c.fn = fn_i; c.zero = z_i; c.rdy = rdy_i; c.exp = o;
    q.push_back(c);
  endtask

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h26: return 4'd3;
      6'h27: return 4'd12;
      default: return 4'd7;
    endcase
  endfunction

  // Expected cycle-by-cycle trace of one instruction; wf/wm are memory wait cycles
  task automatic gen_instr(input logic [5:0] op_i, input logic [5:0] fn_i,
                           input int wf, input int wm, input logic zb);
    outs_t o;
    logic  rdy;
    int    cls;
    for (int i = 0; i <= wf; i++) begin
      o = '0; o.mr = 1; o.srcb = 3'd4; o.aluop = 4'd2;
      rdy = (i == wf); o.pcw = rdy; o.irw = rdy;
      push(o, op_i, fn_i, rdy, 1'($urandom));
    end
    case (op_i)
      6'h00: begin
        if (fn_i == 6'h08) cls = 1;
        else if (fn_i inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) cls = 0;
        else cls = 7;
      end
      6'h02: cls = 2;
      6'h04, 6'h05: cls = 3;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: cls = 4;
      6'h23: cls = 5;
      6'h2B: cls = 6;
      default: cls = 7;
    endcase
    o = '0; o.st = 4'd1; o.aw = 1; o.bw = 1; o.aow = 1; o.srcb = 3'd3; o.aluop = 4'd2;
    o.done = (cls == 7);
    push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
    case (cls)
      0: begin
        o = '0; o.st = 4'd6; o.srca = 1; o.aow = 1; o.aluop = r_alu(fn_i);
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
        o = '0; o.st = 4'd7; o.rdst = 1; o.rw = 1; o.done = 1;
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
      end
      1, 2: begin
        o = '0; o.st = (cls == 1) ? 4'd12 : 4'd9; o.pcsrc = (cls == 1) ? 2'd3 : 2'd2;
        o.pcw = 1; o.done = 1;
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
      end
      3: begin
        o = '0; o.st = 4'd8; o.srca = 1; o.aluop = 4'd6; o.pcsrc = 2'd1; o.done = 1;
        o.pcw = (op_i == 6'h04) ? zb : !zb;
        push(o, op_i, fn_i, 1'($urandom), zb);
      end
      4: begin
        o = '0; o.st = 4'd10; o.srca = 1; o.aow = 1;
        case (op_i)
          6'h08: begin o.srcb = 3'd2; o.aluop = 4'd2; end
          6'h0A: begin o.srcb = 3'd2; o.aluop = 4'd7; end
          6'h0C: begin o.srcb = 3'd5; o.aluop = 4'd0; end
          6'h0D: begin o.srcb = 3'd5; o.aluop = 4'd1; end
          default: begin o.srcb = 3'd5; o.aluop = 4'd3; end
        endcase
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
        o = '0; o.st = 4'd11; o.rw = 1; o.done = 1;
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
      end
      5, 6: begin
        o = '0; o.st = 4'd2; o.srca = 1; o.srcb = 3'd2; o.aluop = 4'd2; o.aow = 1;
        push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= wm; i++) begin
          rdy = (i == wm);
          o = '0; o.iord = 1;
          if (cls == 5) begin o.st = 4'd3; o.mr = 1; o.mdrw = rdy; end
          else begin o.st = 4'd5; o.mw = 1; o.done = rdy; end
          push(o, op_i, fn_i, rdy, 1'($urandom));
        end
        if (cls == 5) begin
          o = '0; o.st = 4'd4; o.m2r = 1; o.rw = 1; o.done = 1;
          push(o, op_i, fn_i, 1'($urandom), 1'($urandom));
        end
      end
      default: ;
    endcase
  endtask

  // Replays the expected trace; entered and left on a falling edge
  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      op = c.op; func = c.fn; zero = c.zero; mem_ready = c.rdy;
      #2;
      chk(tag, c.exp);
      @(negedge clk);
    end
  endtask

  logic [11:0] tbl [21] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26},
    {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h08}, {6'h02, 6'h00}, {6'h04, 6'h00},
    {6'h05, 6'h00}, {6'h08, 6'h00}, {6'h0A, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
    {6'h0E, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h3F, 6'h00}, {6'h00, 6'h00},
    {6'h00, 6'h21}
  };

  outs_t zero_o, e;

  initial begin
    zero_o = '0;
    nrst = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("reset_outputs", zero_o);
    @(negedge clk);
    nrst = 1'b1;

    // directed: add, lw with 3 waits, beq/bne with zero=1, illegal op, wait-limit success
    gen_instr(6'h00, 6'h20, 0, 0, 1'b0);
    gen_instr(6'h23, 6'h11, 0, 3, 1'b0);
    gen_instr(6'h04, 6'h00, 0, 0, 1'b1);
    gen_instr(6'h05, 6'h00, 0, 0, 1'b1);
    gen_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    gen_instr(6'h2B, 6'h00, 15, 15, 1'b0);
    run_q("directed");

    // random instruction mix
    for (int n = 0; n < 40; n++) begin
      logic [11:0] ent;
      logic [5:0]  f;
      ent = tbl[$urandom_range(0, 20)];
      f = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
      gen_instr(ent[11:6], f, (n % 9 == 4) ? 15 : int'($urandom_range(0, 2)),
                (n % 7 == 3) ? 15 : int'($urandom_range(0, 3)), 1'($urandom));
      run_q("random");
    end

    // async reset in the middle of a store's memory phase
    gen_instr(6'h2B, 6'h00, 0, 2, 1'b0);
    void'(q.pop_back());
    run_q("sw_pre_reset");
    mem_ready = 1'b0;
    #2;
    e = '0; e.st = 4'd5; e.mw = 1; e.iord = 1;
    chk("mem_wr_before_reset", e);
    nrst = 1'b0;
    #1;
    chk("mem_wr_async_reset", zero_o);
    @(negedge clk);
    nrst = 1'b1;
    gen_instr(6'h00, 6'h2A, 1, 0, 1'b0);
    run_q("after_async_reset");

    // fetch never acknowledged: timeout into HALT with sticky error
    for (int i = 0; i < 16; i++) begin
      e = '0; e.mr = 1; e.srcb = 3'd4; e.aluop = 4'd2;
      push(e, 6'h00, 6'h20, 1'b0, 1'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e.st = 4'd13; e.halted = 1; e.err = 1;
      push(e, 6'h00, 6'h20, 1'($urandom), 1'($urandom));
    end
    run_q("timeout");
    nrst = 1'b0;
    #2;
    chk("reset_clears_halt", zero_o);
    @(negedge clk);
    nrst = 1'b1;
    gen_instr(6'h0D, 6'h00, 0, 0, 1'b0);
    run_q("after_halt_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
